// File: rtl/crack_ctrl.sv
// crack_ctrl: brute-force key search sequencer. Steps a 24-bit key through
// [KEY_START, KEY_MAX] in KEY_STEP increments, launches the downstream ARC4
// decryptor once per key, snoops its plaintext writes and stops at the first
// key whose plaintext is entirely printable ASCII (8'h20..8'h7E).
module crack_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        arc4_en,
    input  logic        arc4_rdy,
    output logic [23:0] arc4_key,
    input  logic [7:0]  pt_addr,
    input  logic [7:0]  pt_wrdata,
    input  logic        pt_wren,
    output logic [24:0] keys_tried
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [24:0] TRIED_SAT = 25'h1000000;

    state_t      state_q, state_d;
    logic [23:0] arc4_key_q, arc4_key_d;
    logic [23:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic        fail_q, fail_d;
    logic [24:0] keys_tried_q, keys_tried_d;

    logic        pt_bad;
    logic [24:0] next_sum;

    // Byte 0 is the length prefix, so it is exempt from the printable test.
    assign pt_bad   = pt_wren && (pt_addr != 8'h00) &&
                      ((pt_wrdata < 8'h20) || (pt_wrdata > 8'h7E));
    // Carry bit kept so a key step past 24'hFFFFFF terminates instead of wrapping.
    assign next_sum = {1'b0, arc4_key_q} + {1'b0, KEY_STEP};

    // Next-state and Moore/Mealy outputs of the search sequencer.
    always_comb begin
        state_d      = state_q;
        arc4_key_d   = arc4_key_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        fail_d       = fail_q;
        keys_tried_d = keys_tried_q;
        arc4_en      = 1'b0;
        rdy          = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                rdy = 1'b1;
                if (en) begin
                    arc4_key_d   = KEY_START;
                    keys_tried_d = '0;
                    key_valid_d  = 1'b0;
                    fail_d       = 1'b0;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Start pulse only fires once the decryptor can take it.
                arc4_en = arc4_rdy;
                if (arc4_rdy) state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (pt_bad) fail_d = 1'b1;
                if (!arc4_rdy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (pt_bad) fail_d = 1'b1;
                if (arc4_rdy) begin
                    if (keys_tried_q != TRIED_SAT) keys_tried_d = keys_tried_q + 25'd1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!fail_q) begin
                    key_d       = arc4_key_q;
                    key_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (next_sum <= {1'b0, KEY_MAX}) begin
                    arc4_key_d = next_sum[23:0];
                    fail_d     = 1'b0;
                    state_d    = S_LAUNCH;
                end else begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any search in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arc4_key_q   <= KEY_START;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            fail_q       <= 1'b0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            arc4_key_q   <= arc4_key_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            fail_q       <= fail_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign arc4_key   = arc4_key_q;
    assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Directed bench for crack_ctrl. Four instances with different key ranges
// share the decryptor-side inputs; the bench plays the decryptor, emitting a
// printable plaintext only for the chosen pass key.
module tb_crack_ctrl;

    logic        clk;
    logic        rst;
    logic        arc4_rdy;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_wrdata;
    logic        pt_wren;
    logic        en_v [4];
    logic        rdy_v [4];
    logic [23:0] key_v [4];
    logic        kv_v [4];
    logic        ae_v [4];
    logic [23:0] ak_v [4];
    logic [24:0] kt_v [4];

    int checks = 0;
    int failures = 0;

    // 0: defaults; 1: small range; 2: odd keys only; 3: near top of key space
    crack_ctrl u_dut0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .rdy(rdy_v[0]), .key(key_v[0]),
        .key_valid(kv_v[0]), .arc4_en(ae_v[0]), .arc4_rdy(arc4_rdy),
        .arc4_key(ak_v[0]), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
        .pt_wren(pt_wren), .keys_tried(kt_v[0]));
    crack_ctrl #(.KEY_MAX(24'h00000F)) u_dut1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .rdy(rdy_v[1]), .key(key_v[1]),
        .key_valid(kv_v[1]), .arc4_en(ae_v[1]), .arc4_rdy(arc4_rdy),
        .arc4_key(ak_v[1]), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
        .pt_wren(pt_wren), .keys_tried(kt_v[1]));
    crack_ctrl #(.KEY_START(24'h000001), .KEY_STEP(24'h000002), .KEY_MAX(24'h00000F)) u_dut2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .rdy(rdy_v[2]), .key(key_v[2]),
        .key_valid(kv_v[2]), .arc4_en(ae_v[2]), .arc4_rdy(arc4_rdy),
        .arc4_key(ak_v[2]), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
        .pt_wren(pt_wren), .keys_tried(kt_v[2]));
    crack_ctrl #(.KEY_START(24'hFFFFFD), .KEY_STEP(24'h000002)) u_dut3 (
        .clk(clk), .rst(rst), .en(en_v[3]), .rdy(rdy_v[3]), .key(key_v[3]),
        .key_valid(kv_v[3]), .arc4_en(ae_v[3]), .arc4_rdy(arc4_rdy),
        .arc4_key(ak_v[3]), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata),
        .pt_wren(pt_wren), .keys_tried(kt_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse en for one cycle on instance sel; rdy must drop the cycle after.
    task automatic start(input int sel);
        @(negedge clk);
        en_v[sel] = 1'b1;
        @(negedge clk);
        en_v[sel] = 1'b0;
        checks++;
        if (rdy_v[sel] !== 1'b0) begin
            failures++;
            $display("FAIL start_rdy_low dut%0d: got %b exp 0", sel, rdy_v[sel]);
        end
    endtask

    // Called at a negedge with arc4_en high: accept the launch, go busy and
    // write a 4-byte plaintext, leaving the DUT in WAIT_DONE.
    task automatic attempt_to_wait_done(input int sel, input logic [23:0] pass,
                                        input bit no_pass, input bit addr0_only);
        logic [23:0] k;
        bit good;
        k = ak_v[sel];
        good = !no_pass && (k == pass);
        @(negedge clk);
        checks++;
        if (ae_v[sel] !== 1'b0) begin
            failures++;
            $display("FAIL arc4_en_single_pulse dut%0d key %h: got %b exp 0", sel, k, ae_v[sel]);
        end
        arc4_rdy = 1'b0;
        @(negedge clk);
        pt_wren = 1'b1; pt_addr = 8'h00; pt_wrdata = 8'h19;
        if (!addr0_only) begin
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                pt_addr = 8'(i);
                if (good) pt_wrdata = (i == 1) ? 8'h20 : (i == 2) ? 8'h7E : 8'h41;
                else      pt_wrdata = (i != 2) ? 8'h41 : (k[0] ? 8'h1F : 8'h7F);
            end
        end
    endtask

    task automatic finish_attempt();
        @(negedge clk);
        pt_wren = 1'b0;
        arc4_rdy = 1'b1;
    endtask

    // Act as the decryptor until instance sel reports rdy again.
    task automatic run_search(input int sel, input logic [23:0] pass,
                              input bit no_pass, input bit addr0_only);
        int cyc;
        cyc = 0;
        while (rdy_v[sel] !== 1'b1 && cyc < 2000) begin
            if (ae_v[sel] === 1'b1) begin
                attempt_to_wait_done(sel, pass, no_pass, addr0_only);
                finish_attempt();
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (rdy_v[sel] !== 1'b1) begin
            failures++;
            $display("FAIL search_timeout dut%0d: rdy got %b exp 1", sel, rdy_v[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdy_v[i] !== 1'b1 || key_v[i] !== 24'h0 || kv_v[i] !== 1'b0 ||
                ae_v[i] !== 1'b0 || kt_v[i] !== 25'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: rdy=%b key=%h kv=%b ae=%b kt=%h exp 1/0/0/0/0",
                         i, rdy_v[i], key_v[i], kv_v[i], ae_v[i], kt_v[i]);
            end
        end
        checks++;
        if (ak_v[0] !== 24'h000000 || ak_v[2] !== 24'h000001 || ak_v[3] !== 24'hFFFFFD) begin
            failures++;
            $display("FAIL reset_arc4_key: got %h %h %h exp 000000 000001 fffffd",
                     ak_v[0], ak_v[2], ak_v[3]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Decryptor not ready in LAUNCH: no pulse, state held, and stray bad
    // writes outside the busy window do not spoil key 0.
    task automatic test_launch_hold();
        arc4_rdy = 1'b0;
        pt_wren = 1'b1; pt_addr = 8'h05; pt_wrdata = 8'h00;
        start(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ae_v[0] !== 1'b0 || rdy_v[0] !== 1'b0 || ak_v[0] !== 24'h0) begin
                failures++;
                $display("FAIL launch_hold cyc%0d: ae=%b rdy=%b ak=%h exp 0/0/000000",
                         i, ae_v[0], rdy_v[0], ak_v[0]);
            end
        end
        pt_wren = 1'b0;
        arc4_rdy = 1'b1;
        #1;
        checks++;
        if (ae_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL launch_pulse: arc4_en got %b exp 1", ae_v[0]);
        end
        run_search(0, 24'h000000, 1'b0, 1'b0);
        checks++;
        if (kt_v[0] !== 25'd1 || key_v[0] !== 24'h0 || kv_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL launch_result: kt=%0d key=%h kv=%b exp 1/000000/1",
                     kt_v[0], key_v[0], kv_v[0]);
        end
    endtask

    // Only the length byte is non-printable: the first key must be accepted.
    task automatic test_addr0();
        start(0);
        run_search(0, 24'h000000, 1'b1, 1'b1);
        checks++;
        if (kt_v[0] !== 25'd1 || key_v[0] !== 24'h0 || kv_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL addr0_ignored: kt=%0d key=%h kv=%b exp 1/000000/1",
                     kt_v[0], key_v[0], kv_v[0]);
        end
    endtask

    task automatic test_search();
        start(0);
        run_search(0, 24'h000018, 1'b0, 1'b0);
        checks++;
        if (kt_v[0] !== 25'd25 || key_v[0] !== 24'h000018 || kv_v[0] !== 1'b1 || rdy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL search_0x18: kt=%0d key=%h kv=%b rdy=%b exp 25/000018/1/1",
                     kt_v[0], key_v[0], kv_v[0], rdy_v[0]);
        end
    endtask

    // Restart from DONE, en ignored while busy, then async reset mid-attempt.
    task automatic test_busy_en_and_reset();
        int cyc;
        start(0);
        checks++;
        if (kv_v[0] !== 1'b0 || kt_v[0] !== 25'd0) begin
            failures++;
            $display("FAIL restart_clear: kv=%b kt=%0d exp 0/0", kv_v[0], kt_v[0]);
        end
        attempt_to_wait_done(0, 24'h000018, 1'b0, 1'b0);
        finish_attempt();
        cyc = 0;
        while (ae_v[0] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ae_v[0] !== 1'b1 || ak_v[0] !== 24'h000001) begin
            failures++;
            $display("FAIL second_launch: ae=%b ak=%h exp 1/000001", ae_v[0], ak_v[0]);
        end
        attempt_to_wait_done(0, 24'h000018, 1'b0, 1'b0);
        @(negedge clk);
        pt_wren = 1'b0;
        en_v[0] = 1'b1;
        @(negedge clk);
        en_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_v[0] !== 1'b0 || ak_v[0] !== 24'h000001 || kt_v[0] !== 25'd1) begin
            failures++;
            $display("FAIL busy_en_ignored: rdy=%b ak=%h kt=%0d exp 0/000001/1",
                     rdy_v[0], ak_v[0], kt_v[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy_v[0] !== 1'b1 || ak_v[0] !== 24'h0 || kt_v[0] !== 25'd0 ||
            kv_v[0] !== 1'b0 || key_v[0] !== 24'h0 || ae_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midsearch_reset: rdy=%b ak=%h kt=%0d kv=%b key=%h ae=%b exp 1/0/0/0/0/0",
                     rdy_v[0], ak_v[0], kt_v[0], kv_v[0], key_v[0], ae_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        arc4_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_v[0] !== 1'b1 || ae_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: rdy=%b ae=%b exp 1/0", rdy_v[0], ae_v[0]);
        end
    endtask

    task automatic test_exhaust_small();
        start(1);
        run_search(1, 24'h0, 1'b1, 1'b0);
        checks++;
        if (kt_v[1] !== 25'd16 || kv_v[1] !== 1'b0 || key_v[1] !== 24'h0) begin
            failures++;
            $display("FAIL exhaust_0xF: kt=%0d kv=%b key=%h exp 16/0/000000",
                     kt_v[1], kv_v[1], key_v[1]);
        end
    endtask

    task automatic test_odd_step();
        start(2);
        run_search(2, 24'h000006, 1'b0, 1'b0);
        checks++;
        if (kt_v[2] !== 25'd8 || kv_v[2] !== 1'b0 || key_v[2] !== 24'h0) begin
            failures++;
            $display("FAIL step2_even_miss: kt=%0d kv=%b key=%h exp 8/0/000000",
                     kt_v[2], kv_v[2], key_v[2]);
        end
        start(2);
        run_search(2, 24'h000007, 1'b0, 1'b0);
        checks++;
        if (kt_v[2] !== 25'd4 || kv_v[2] !== 1'b1 || key_v[2] !== 24'h000007) begin
            failures++;
            $display("FAIL step2_odd_hit: kt=%0d kv=%b key=%h exp 4/1/000007",
                     kt_v[2], kv_v[2], key_v[2]);
        end
    endtask

    // FFFFFD, FFFFFF, then the step carries out of 24 bits: stop, no wrap.
    task automatic test_overflow();
        start(3);
        run_search(3, 24'h0, 1'b1, 1'b0);
        checks++;
        if (kt_v[3] !== 25'd2 || kv_v[3] !== 1'b0 || key_v[3] !== 24'h0 || ak_v[3] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL overflow_stop: kt=%0d kv=%b key=%h ak=%h exp 2/0/000000/ffffff",
                     kt_v[3], kv_v[3], key_v[3], ak_v[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) en_v[i] = 1'b0;
        arc4_rdy = 1'b1;
        pt_addr = 8'h00;
        pt_wrdata = 8'h00;
        pt_wren = 1'b0;
        test_reset();
        test_launch_hold();
        test_addr0();
        test_search();
        test_busy_en_and_reset();
        test_exhaust_small();
        test_odd_step();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
